squeeze_serializer: RTL and testbench
=====================================

# squeeze_serializer

Output stage of the Haraka-S sponge, directly downstream of the input deserializer and the permutation core. It accepts full-rate squeezed blocks (BLKWIDTH bits) from the sponge and emits them as WIDTH-bit words over a valid/ready stream, least-significant word first. It stops after exactly the requested number of output words, requesting only as many blocks as that length needs.

## Interface
- BLKWIDTH, 256, squeezed block width in bits; must be a multiple of WIDTH.
- WIDTH, 8, output word width in bits.
- LENWIDTH, 16, width of the requested-length field.
- NWORDS (localparam), BLKWIDTH/WIDTH, words per block (32 at defaults).

- clk  input  1  single clock, rising edge.
- clear  input  1  asynchronous, active-high reset.
- start  input  1  begin a squeeze; sampled only in IDLE.
- out_len  input  LENWIDTH  number of WIDTH-bit words to emit; sampled with start.
- blk_in  input  BLKWIDTH  squeezed block; word 0 is blk_in[WIDTH-1:0].
- blk_valid  input  1  blk_in is valid.
- blk_ready  output  1  block accepted on the edge where blk_valid && blk_ready.
- dout  output  WIDTH  output word.
- dout_valid  output  1  dout is valid.
- dout_ready  input  1  sink accepts dout on the edge where dout_valid && dout_ready.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse after the final word's handshake, or after a zero-length start.

## Operation
- States: IDLE, WAIT_BLK, SHIFT, DONE.
- IDLE
  - start with out_len != 0: latch out_len into `remaining`, then go to WAIT_BLK.
  - start with out_len == 0: go to DONE. No block is requested.
- WAIT_BLK
  - blk_ready = 1.
  - On a block handshake: load the shift register, clear `word_idx`, then go to SHIFT.
- SHIFT
  - dout_valid = 1; dout is the low WIDTH bits of the shift register.
  - On each output handshake: shift right by WIDTH, decrement `remaining`, increment `word_idx`.
  - If `remaining` reaches 0, go to DONE.
  - Otherwise, if `word_idx` reaches NWORDS, the block is exhausted; go to WAIT_BLK.
- DONE
  - done = 1 for one cycle, then go to IDLE.
- start is ignored while busy. out_len changes after the start edge have no effect.
- dout and dout_valid are held stable while dout_valid && !dout_ready.
- The tail of the last block beyond out_len is discarded. No extra block is ever requested.
- `remaining` is LENWIDTH bits. `word_idx` is clog2(NWORDS)+1 bits, so NWORDS is representable.

## Timing
- Reset values: blk_ready=0, dout=0, dout_valid=0, busy=0, done=0. Internal state: IDLE, shift register 0, counters 0, skid buffer empty.
- clear acts immediately, in any state. The current squeeze is abandoned and no done pulse is produced.
- Block handshake to first dout_valid: 1 cycle.
- start to blk_ready: 1 cycle.
- Throughput with dout_ready held high: 1 word/cycle within a block.
- Block boundary without the skid buffer: a 1-cycle bubble on dout_valid (WAIT_BLK state) plus the producer's own latency.
- Final word's handshake to done: done is high in the following cycle. busy falls the cycle after that.
- Zero-length start: done is high in the cycle after start.

## Configuration
- SQUEEZE_SKID_EN defined: a one-entry block buffer is compiled in.
  - In SHIFT, blk_ready = buffer empty && `remaining` > (NWORDS − `word_idx`). A block is requested only if the length needs one.
  - When the last word of the current block is handshaken and the buffer is full, the buffer loads the shift register on that same edge. SHIFT continues with no bubble.
  - If the buffer is empty at that point, the FSM enters WAIT_BLK as normal.
- SQUEEZE_SKID_EN undefined: no buffer. blk_ready is asserted only in WAIT_BLK, and every block boundary costs 1 bubble cycle.

## Test plan
- Reset: assert clear mid-SHIFT -> all outputs 0 immediately. The next start works normally.
- Single block: block byte i = i, out_len=32, dout_ready=1, blk_valid held high -> dout = 0x00..0x1F on 32 consecutive cycles, then done for 1 cycle. Exactly 1 block is accepted.
- Two blocks: block 0 bytes 0x00..0x1F, block 1 bytes 0x20..0x3F, out_len=40 -> dout = 0x00..0x27, then done. Exactly 2 blocks are accepted. dout_valid gaps between the 0x1F and 0x20 words: 1 without SQUEEZE_SKID_EN, 0 with it.
- Backpressure: out_len=8, dout_ready alternating 1/0 -> each byte is held stable while dout_ready=0. 8 handshakes, bytes in order, done once.
- Zero length: start with out_len=0 -> done high the next cycle; blk_ready and dout_valid are never asserted.
- Exact fit: out_len=64 with SQUEEZE_SKID_EN -> exactly 2 block handshakes. blk_ready is 0 throughout the second block.

Source files
------------

// File: rtl/squeeze_serializer.sv
// Haraka-S squeeze output stage: accepts BLKWIDTH-bit squeezed blocks and emits out_len WIDTH-bit words, LSW first.
// Define SQUEEZE_SKID_EN to compile in a one-entry block buffer that hides the block-boundary bubble.
module squeeze_serializer #(
    parameter int BLKWIDTH = 256,
    parameter int WIDTH    = 8,
    parameter int LENWIDTH = 16
) (
    input  logic                clk,
    input  logic                clear,
    input  logic                start,
    input  logic [LENWIDTH-1:0] out_len,
    input  logic [BLKWIDTH-1:0] blk_in,
    input  logic                blk_valid,
    output logic                blk_ready,
    output logic [WIDTH-1:0]    dout,
    output logic                dout_valid,
    input  logic                dout_ready,
    output logic                busy,
    output logic                done
);
    localparam int NWORDS = BLKWIDTH / WIDTH;
    localparam int IDXW   = $clog2(NWORDS) + 1;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_BLK = 2'd1,
        SHIFT    = 2'd2,
        DONE     = 2'd3
    } state_t;

    state_t              state_r, state_s;
    logic [BLKWIDTH-1:0] shift_r, shift_s;
    logic [LENWIDTH-1:0] remaining_r, remaining_s;
    logic [IDXW-1:0]     word_idx_r, word_idx_s, idx_inc_s;
    logic                blk_ready_s;
    logic                blk_hs_s;
    logic                dout_hs_s;
`ifdef SQUEEZE_SKID_EN
    localparam int LW1 = LENWIDTH + 1;
    logic [BLKWIDTH-1:0] buf_r, buf_s;
    logic                buf_full_r, buf_full_s;
    logic [LENWIDTH:0]   span_s;
`endif

    assign blk_hs_s  = blk_valid && blk_ready;
    assign dout_hs_s = dout_valid && dout_ready;
    assign dout      = shift_r[WIDTH-1:0];

    // Next-state, datapath and next-output decode
    always_comb begin
        state_s     = state_r;
        shift_s     = shift_r;
        remaining_s = remaining_r;
        word_idx_s  = word_idx_r;
        idx_inc_s   = word_idx_r + IDXW'(1);
        blk_ready_s = 1'b0;
`ifdef SQUEEZE_SKID_EN
        buf_s       = buf_r;
        buf_full_s  = buf_full_r;
        span_s      = {LW1{1'b0}};
`endif
        case (state_r)
            IDLE: begin
                if (start) begin
                    if (out_len != {LENWIDTH{1'b0}}) begin
                        remaining_s = out_len;
                        state_s     = WAIT_BLK;
                    end else begin
                        state_s = DONE;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            WAIT_BLK: begin
                if (blk_hs_s) begin
                    shift_s    = blk_in;
                    word_idx_s = {IDXW{1'b0}};
                    state_s    = SHIFT;
                end else begin
                    state_s = WAIT_BLK;
                end
            end
            SHIFT: begin
`ifdef SQUEEZE_SKID_EN
                if (blk_hs_s) begin
                    buf_s      = blk_in;
                    buf_full_s = 1'b1;
                end else begin
                    buf_s = buf_r;
                end
`endif
                if (dout_hs_s) begin
                    shift_s     = shift_r >> WIDTH;
                    remaining_s = remaining_r - LENWIDTH'(1);
                    word_idx_s  = idx_inc_s;
                    if (remaining_r == LENWIDTH'(1)) begin
                        state_s = DONE;
                    end else if (idx_inc_s == IDXW'(NWORDS)) begin
`ifdef SQUEEZE_SKID_EN
                        // A block arriving on the boundary edge goes straight into the shifter
                        if (buf_full_r || blk_hs_s) begin
                            shift_s    = buf_full_r ? buf_r : blk_in;
                            word_idx_s = {IDXW{1'b0}};
                            buf_full_s = 1'b0;
                            state_s    = SHIFT;
                        end else begin
                            state_s = WAIT_BLK;
                        end
`else
                        state_s = WAIT_BLK;
`endif
                    end else begin
                        state_s = SHIFT;
                    end
                end else begin
                    state_s = SHIFT;
                end
            end
            DONE: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase

        if (state_s == WAIT_BLK) begin
            blk_ready_s = 1'b1;
        end
`ifdef SQUEEZE_SKID_EN
        else if (state_s == SHIFT) begin
            span_s      = LW1'(NWORDS) - LW1'(word_idx_s);
            blk_ready_s = !buf_full_s && ({1'b0, remaining_s} > span_s);
        end
`endif
        else begin
            blk_ready_s = 1'b0;
        end
    end

    // State, datapath and registered outputs
    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            state_r     <= IDLE;
            shift_r     <= {BLKWIDTH{1'b0}};
            remaining_r <= {LENWIDTH{1'b0}};
            word_idx_r  <= {IDXW{1'b0}};
            blk_ready   <= 1'b0;
            dout_valid  <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            state_r     <= state_s;
            shift_r     <= shift_s;
            remaining_r <= remaining_s;
            word_idx_r  <= word_idx_s;
            blk_ready   <= blk_ready_s;
            dout_valid  <= (state_s == SHIFT);
            busy        <= (state_s != IDLE);
            done        <= (state_s == DONE);
        end
    end

`ifdef SQUEEZE_SKID_EN
    // One-entry block buffer
    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            buf_r      <= {BLKWIDTH{1'b0}};
            buf_full_r <= 1'b0;
        end else begin
            buf_r      <= buf_s;
            buf_full_r <= buf_full_s;
        end
    end
`endif

endmodule

// File: tb/tb_squeeze_serializer.sv
// Bench for squeeze_serializer: directed cases plus randomized squeezes, checked every cycle
// against a word-stream model (accepted blocks become a queue of expected words).
module tb_squeeze_serializer;
    localparam int BLKWIDTH = 256;
    localparam int WIDTH    = 8;
    localparam int LENWIDTH = 16;
    localparam int NWORDS   = BLKWIDTH / WIDTH;
`ifdef SQUEEZE_SKID_EN
    localparam int EXP_GAP = 0;
`else
    localparam int EXP_GAP = 1;
`endif

    logic                clk = 1'b0;
    logic                clear = 1'b1;
    logic                start = 1'b0;
    logic [LENWIDTH-1:0] out_len = '0;
    logic [BLKWIDTH-1:0] blk_in = '0;
    logic                blk_valid = 1'b0;
    logic                blk_ready;
    logic [WIDTH-1:0]    dout;
    logic                dout_valid;
    logic                dout_ready = 1'b1;
    logic                busy;
    logic                done;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // model state
    logic [7:0] exp_q[$];
    logic [7:0] log_q[$];
    int         hs_cyc[$];
    int         cur_len = 0, blocks_needed = 0, blocks_acc = 0, words_done = 0;
    int         done_cnt = 0, blk_hs_total = 0;
    bit         exp_done = 0, exp_busy = 0, dv_known = 0, exp_dv = 0, hold = 0, rdy_known = 0;
    logic [7:0] prev_dout = '0;

    // stimulus modes
    int         blk_mode = 0;   // 0: blk_valid held high, 1: random
    int         rdy_mode = 0;   // 0: ready high, 1: random, 2: alternating
    bit         seq_mode = 1;
    logic [7:0] next_byte = '0;

    squeeze_serializer #(.BLKWIDTH(BLKWIDTH), .WIDTH(WIDTH), .LENWIDTH(LENWIDTH)) dut (
        .clk(clk), .clear(clear), .start(start), .out_len(out_len),
        .blk_in(blk_in), .blk_valid(blk_valid), .blk_ready(blk_ready),
        .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready),
        .busy(busy), .done(done)
    );

    initial forever #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc = cyc + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic gen_block();
        for (int j = 0; j < NWORDS; j++) begin
            if (seq_mode) begin
                blk_in[j*WIDTH +: WIDTH] = next_byte;
                next_byte = next_byte + 8'd1;
            end else begin
                blk_in[j*WIDTH +: WIDTH] = 8'($urandom);
            end
        end
    endtask

    function automatic logic [7:0] lw(input int i);
        if (i < log_q.size()) return log_q[i];
        return 8'hxx;
    endfunction

    function automatic int gap_at(input int i);
        if (i < hs_cyc.size() && i > 0) return hs_cyc[i] - hs_cyc[i-1] - 1;
        return -1;
    endfunction

    // producer and sink: new block after each block handshake, ready per mode
    initial begin
        int seen;
        seen = 0;
        forever begin
            @(posedge clk);
            #1;
            if (blk_hs_total != seen) begin
                seen = blk_hs_total;
                gen_block();
            end
            blk_valid = (blk_mode == 0) ? 1'b1 : ($urandom_range(0, 2) != 0);
            case (rdy_mode)
                0: dout_ready = 1'b1;
                1: dout_ready = 1'($urandom);
                default: dout_ready = ~dout_ready;
            endcase
        end
    end

    // compare process: checks the DUT against the word-stream model every cycle
    initial begin
        logic [7:0] w;
        bit nd_done, nd_dv_known, nd_dv, nd_rdy, nb;
        forever begin
            @(negedge clk);
            if (clear) begin
                exp_q.delete();
                exp_done = 0; exp_busy = 0; dv_known = 0; hold = 0; rdy_known = 0;
                cur_len = 0; blocks_needed = 0; blocks_acc = 0; words_done = 0;
            end else begin
                chk("done", 32'(done), 32'(exp_done));
                chk("busy", 32'(busy), 32'(exp_busy));
                if (dv_known) chk("dout_valid_timing", 32'(dout_valid), 32'(exp_dv));
                if (hold) begin
                    chk("hold_valid", 32'(dout_valid), 32'd1);
                    chk("hold_data", 32'(dout), 32'(prev_dout));
                end
                if (rdy_known) chk("start_to_blk_ready", 32'(blk_ready), 32'd1);
                if (!exp_busy) chk("idle_quiet", 32'({dout_valid, blk_ready}), 32'd0);
                if (blk_ready) chk("blk_ready_needed", 32'(blocks_acc < blocks_needed), 32'd1);

                nd_done = 0; nd_dv_known = 0; nd_dv = 0; nd_rdy = 0;
                if (blk_valid && blk_ready) begin
                    for (int j = 0; j < NWORDS; j++) exp_q.push_back(blk_in[j*WIDTH +: WIDTH]);
                    blocks_acc = blocks_acc + 1;
                    blk_hs_total = blk_hs_total + 1;
                    if (!dout_valid) begin
                        nd_dv_known = 1;
                        nd_dv = 1;
                    end
                end
                if (dout_valid && dout_ready) begin
                    chk("len_not_exceeded", 32'(words_done < cur_len), 32'd1);
                    chk("word_available", 32'(exp_q.size() != 0), 32'd1);
                    if (exp_q.size() != 0) begin
                        w = exp_q.pop_front();
                        chk("dout", 32'(dout), 32'(w));
                    end
                    words_done = words_done + 1;
                    log_q.push_back(dout);
                    hs_cyc.push_back(cyc);
                    nd_dv_known = 1;
                    if (words_done == cur_len) begin
                        nd_done = 1;
                        nd_dv = 0;
                    end else begin
                        nd_dv = (exp_q.size() != 0);
                    end
                end
                if (done) begin
                    chk("final_word_count", 32'(words_done), 32'(cur_len));
                    chk("block_count", 32'(blocks_acc), 32'(blocks_needed));
                    done_cnt = done_cnt + 1;
                end
                nb = exp_busy;
                if (exp_done) nb = 0;
                if (start && !exp_busy) begin
                    cur_len = int'(out_len);
                    blocks_needed = (cur_len + NWORDS - 1) / NWORDS;
                    words_done = 0;
                    blocks_acc = 0;
                    exp_q.delete();
                    log_q.delete();
                    hs_cyc.delete();
                    nb = 1;
                    if (cur_len == 0) nd_done = 1;
                    else nd_rdy = 1;
                end
                hold = dout_valid && !dout_ready;
                prev_dout = dout;
                exp_done = nd_done;
                exp_busy = nb;
                dv_known = nd_dv_known;
                exp_dv = nd_dv;
                rdy_known = nd_rdy;
            end
        end
    end

    task automatic set_stream(input bit seq, input logic [7:0] first);
        seq_mode = seq;
        next_byte = first;
        gen_block();
    endtask

    task automatic run_squeeze(input int len, input bit noisy);
        int d0;
        int budget;
        @(posedge clk);
        #2;
        d0 = done_cnt;
        start = 1'b1;
        out_len = LENWIDTH'(len);
        @(posedge clk);
        #2;
        start = 1'b0;
        out_len = LENWIDTH'($urandom);
        budget = len * 12 + 200;
        while (done_cnt == d0 && budget > 0) begin
            if (noisy) begin
                start = 1'($urandom);
                out_len = LENWIDTH'($urandom);
            end
            @(posedge clk);
            #2;
            budget = budget - 1;
        end
        start = 1'b0;
        chk("squeeze_completed", 32'(done_cnt != d0), 32'd1);
        if (done_cnt == d0) begin
            clear = 1'b1;
            @(posedge clk);
            #2;
            clear = 1'b0;
        end
    endtask

    initial begin
        int d0;
        int len;
        repeat (3) @(posedge clk);
        #2;
        chk("reset_blk_ready", 32'(blk_ready), 32'd0);
        chk("reset_dout", 32'(dout), 32'd0);
        chk("reset_dout_valid", 32'(dout_valid), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        clear = 1'b0;

        // clear in the middle of SHIFT
        blk_mode = 0; rdy_mode = 0;
        set_stream(1, 8'h00);
        @(posedge clk);
        #2;
        start = 1'b1;
        out_len = 16'd40;
        @(posedge clk);
        #2;
        start = 1'b0;
        repeat (6) @(posedge clk);
        #2;
        chk("pre_clear_shifting", 32'(dout_valid), 32'd1);
        d0 = done_cnt;
        clear = 1'b1;
        #1;
        chk("clear_dout", 32'(dout), 32'd0);
        chk("clear_dout_valid", 32'(dout_valid), 32'd0);
        chk("clear_blk_ready", 32'(blk_ready), 32'd0);
        chk("clear_busy", 32'(busy), 32'd0);
        chk("clear_done", 32'(done), 32'd0);
        @(posedge clk);
        #2;
        clear = 1'b0;
        repeat (3) @(posedge clk);
        chk("no_done_after_clear", 32'(done_cnt), 32'(d0));

        // single block
        set_stream(1, 8'h00);
        run_squeeze(32, 0);
        chk("single_len", 32'(log_q.size()), 32'd32);
        chk("single_first", 32'(lw(0)), 32'h00);
        chk("single_last", 32'(lw(31)), 32'h1F);
        chk("single_blocks", 32'(blocks_acc), 32'd1);
        chk("single_back_to_back", 32'(hs_cyc.size() == 32 ? hs_cyc[31] - hs_cyc[0] : -1), 32'd31);

        // two blocks
        set_stream(1, 8'h00);
        run_squeeze(40, 0);
        chk("two_len", 32'(log_q.size()), 32'd40);
        chk("two_word32", 32'(lw(32)), 32'h20);
        chk("two_last", 32'(lw(39)), 32'h27);
        chk("two_blocks", 32'(blocks_acc), 32'd2);
        chk("two_boundary_gap", 32'(gap_at(32)), 32'(EXP_GAP));

        // backpressure
        rdy_mode = 2;
        set_stream(1, 8'h00);
        d0 = done_cnt;
        run_squeeze(8, 0);
        repeat (5) @(posedge clk);
        chk("bp_len", 32'(log_q.size()), 32'd8);
        chk("bp_first", 32'(lw(0)), 32'h00);
        chk("bp_last", 32'(lw(7)), 32'h07);
        chk("bp_done_once", 32'(done_cnt - d0), 32'd1);
        rdy_mode = 0;

        // zero length
        run_squeeze(0, 0);
        chk("zero_words", 32'(log_q.size()), 32'd0);
        chk("zero_blocks", 32'(blocks_acc), 32'd0);

        // exact fit
        set_stream(1, 8'h00);
        run_squeeze(64, 0);
        chk("fit_blocks", 32'(blocks_acc), 32'd2);
        chk("fit_last", 32'(lw(63)), 32'h3F);

        // randomized squeezes
        for (int i = 0; i < 40; i++) begin
            blk_mode = int'($urandom_range(0, 1));
            rdy_mode = int'($urandom_range(0, 2));
            set_stream(0, 8'h00);
            case ($urandom_range(0, 4))
                0: len = 32 * int'($urandom_range(1, 3));
                1: len = int'($urandom_range(0, 2));
                default: len = int'($urandom_range(0, 100));
            endcase
            run_squeeze(len, 1);
        end

        repeat (4) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
